deint_rx_scheduler: RTL and testbench
=====================================

// Module: deint_rx_scheduler
// PURPOSE
// - Sequences the receive-side bit deinterleaver for one 802.11a packet.
// - Forwards the demapper bit stream to the deinterleaver: first the SIGNAL symbol (mode 00),
//   then N DATA symbols at the mode decoded from the SIGNAL RATE field.
// - Holds off input while SIGNAL is decoded, clears the deinterleaver before a mode change,
//   flushes the last symbol out, and reports done/error.
// PARAMETERS
// - NSYM_W        10    width of the DATA symbol count
// - SIG_TIMEOUT   1024  max cycles in SIG_WAIT before an error
// - FLUSH_CYCLES  320   cycles held in FLUSH after the last bit (>= 288 + 2)
// PORTS
// - clock      in   1       system clock
// - reset      in   1       synchronous, active-high
// - pkt_start  in   1       pulse: begin a packet (ignored unless IDLE)
// - abort      in   1       pulse: cancel the packet from any state
// - sig_rate   in   4       RATE bits R1..R4; valid with sig_valid
// - sig_nsym   in   NSYM_W  number of DATA symbols; valid with sig_valid
// - sig_valid  in   1       pulse: SIGNAL decoded OK
// - sig_error  in   1       pulse: SIGNAL parity/format failure
// - in_bit     in   1       demapped coded bit
// - in_valid   in   1       in_bit valid
// - in_ready   out  1       bit accepted when in_valid & in_ready
// - dint_data  out  1       to deinterleaver inputData
// - dint_valid out  1       to deinterleaver inputValid
// - dint_mode  out  2       00/01/10/11 -> NCBPS 48/96/192/288
// - dint_reset out  1       one-cycle clear pulse to the deinterleaver
// - busy       out  1       high in every state except IDLE
// - done       out  1       one-cycle pulse: packet finished cleanly
// - err        out  1       one-cycle pulse: bad rate, nsym==0, timeout or abort
// - sym_count  out  NSYM_W  DATA symbols fully forwarded so far
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except dint_mode=00; counters cleared.
// - States: IDLE -> SIG_LOAD -> SIG_WAIT -> RECONF -> DATA -> FLUSH -> IDLE.
// - IDLE: on pkt_start, go to SIG_LOAD with dint_mode=00. bit_cnt=0, sym_count=0.
// - SIG_LOAD: in_ready=1. Forward 48 bits. On the 48th accept, go to SIG_WAIT.
// - SIG_WAIT: in_ready=0. Wait timer counts up.
//   - sig_error, or sig_error & sig_valid together -> err, go to IDLE.
//   - sig_valid with a legal rate and nsym != 0 -> latch mode and nsym, go to RECONF.
//   - sig_valid with an illegal rate or nsym == 0 -> err, go to IDLE.
//   - SIG_TIMEOUT cycles reached -> err, go to IDLE.
// - Rate map (R1..R4 -> mode):
//   - 1101, 1111 -> 00
//   - 0101, 0111 -> 01
//   - 1001, 1011 -> 10
//   - 0001, 0011 -> 11
//   - all other codes are illegal.
// - RECONF: one cycle. dint_reset=1, dint_mode updates this cycle, in_ready=0. Then go to DATA.
// - DATA: in_ready=1.
//   - bit_cnt wraps at NCBPS(mode)-1; sym_count increments on each wrap.
//   - On the accept that completes symbol nsym, set in_ready=0 that cycle and go to FLUSH.
// - FLUSH: in_ready=0, dint_valid=0. After FLUSH_CYCLES cycles, pulse done, go to IDLE.
// - Datapath: dint_data/dint_valid are registered. dint_valid=1 exactly one cycle after each
//   accepted bit; there is no combinational path from in_bit to dint_data.
//   dint_data keeps its last value when dint_valid=0.
// - in_ready is combinational from state and counters only; it never depends on in_valid.
// - dint_mode is stable from RECONF until the next RECONF or reset; SIG_LOAD forces 00.
// - abort in any non-IDLE state: go to IDLE next cycle, pulse dint_reset and err, no done.
//   abort beats pkt_start. abort in IDLE is ignored.
// - pkt_start while busy is ignored. sig_valid/sig_error outside SIG_WAIT are ignored.
// - done and err are never asserted in the same cycle.
// - Arithmetic: bit_cnt is 9 bits (max 287). sym_count saturates at 2^NSYM_W-1.
// STRUCTURE
// - Package phy_pkg:
//   - mode encodings MODE_BPSK..MODE_64QAM
//   - NCBPS constants 48/96/192/288
//   - RATE code constants
//   - function ncbps_of(mode)
//   - state enum
// - Sub-module phy_rate_lut: combinational sig_rate -> {legal, mode}, shared with the TX side.
// - Top contains the FSM, bit/symbol counters, wait/flush timer and output registers.
// TESTING
// - Reset values:
//   - reset held for 3 cycles -> busy=0, in_ready=0, dint_valid=0, dint_mode=00, done=0, err=0.
// - 6 Mb/s packet:
//   - stimulus: pkt_start; 48 bits; sig_valid with rate=1101, nsym=2; 96 bits with in_valid held high.
//   - response: 144 dint_valid cycles, each 1 cycle after its accept; dint_mode stays 00;
//     dint_reset pulses once; sym_count=2; done pulses FLUSH_CYCLES after the last bit.
// - 54 Mb/s packet with gaps:
//   - stimulus: rate=0011, nsym=3; in_valid toggling 50%.
//   - response: dint_mode=11 from RECONF; exactly 864 data bits forwarded in order;
//     in_ready drops on the accept of bit 864.
// - Illegal rate:
//   - stimulus: sig_valid with rate=0000.
//   - response: err pulses; busy=0 next cycle; no dint_reset; no DATA bits accepted.
// - Timeout, and error precedence:
//   - no sig_valid within 1024 cycles -> err.
//   - sig_valid & sig_error in the same cycle -> err, no RECONF.
// - Abort and restart:
//   - stimulus: abort at DATA bit 100 of a 16QAM packet.
//   - response: IDLE next cycle with dint_reset=1, err=1.
//   - then pkt_start -> a clean 48-bit SIGNAL phase at mode 00.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared 802.11a PHY definitions: modulation modes, NCBPS sizes, RATE codes
// and the receive scheduler state encoding.
package phy_pkg;

   typedef enum logic [1:0] {
      MODE_BPSK  = 2'b00,
      MODE_QPSK  = 2'b01,
      MODE_16QAM = 2'b10,
      MODE_64QAM = 2'b11
   } mode_t;

   localparam logic [8:0] NCBPS_BPSK  = 9'd48;
   localparam logic [8:0] NCBPS_QPSK  = 9'd96;
   localparam logic [8:0] NCBPS_16QAM = 9'd192;
   localparam logic [8:0] NCBPS_64QAM = 9'd288;

   // RATE field R1..R4, R1 in bit 3
   localparam logic [3:0] RATE_6  = 4'b1101;
   localparam logic [3:0] RATE_9  = 4'b1111;
   localparam logic [3:0] RATE_12 = 4'b0101;
   localparam logic [3:0] RATE_18 = 4'b0111;
   localparam logic [3:0] RATE_24 = 4'b1001;
   localparam logic [3:0] RATE_36 = 4'b1011;
   localparam logic [3:0] RATE_48 = 4'b0001;
   localparam logic [3:0] RATE_54 = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SIG_LOAD,
      ST_SIG_WAIT,
      ST_RECONF,
      ST_DATA,
      ST_FLUSH
   } state_t;

   function automatic logic [8:0] ncbps_of(input mode_t mode);
      case (mode)
         MODE_BPSK:  return NCBPS_BPSK;
         MODE_QPSK:  return NCBPS_QPSK;
         MODE_16QAM: return NCBPS_16QAM;
         default:    return NCBPS_64QAM;
      endcase
   endfunction

endpackage

// File: rtl/deint_rx_scheduler_if.sv
// Demapper-to-scheduler bit stream plus the scheduler-to-deinterleaver control bus.
interface deint_rx_scheduler_if;
   logic       in_bit;
   logic       in_valid;
   logic       in_ready;
   logic       dint_data;
   logic       dint_valid;
   logic [1:0] dint_mode;
   logic       dint_reset;

   modport master (
      input  in_bit, in_valid,
      output in_ready, dint_data, dint_valid, dint_mode, dint_reset
   );

   modport slave (
      output in_bit, in_valid,
      input  in_ready, dint_data, dint_valid, dint_mode, dint_reset
   );
endinterface

// File: rtl/phy_rate_lut.sv
// SIGNAL RATE field decoder: maps R1..R4 to a modulation mode and flags
// the eight legal codes. Purely combinational; shared with the TX side.
module phy_rate_lut
   import phy_pkg::*;
(
   input  logic [3:0] rate,
   output logic       legal,
   output mode_t      mode
);

   always_comb begin
      legal = 1'b1;
      mode  = MODE_BPSK;
      case (rate)
         RATE_6,  RATE_9:  mode = MODE_BPSK;
         RATE_12, RATE_18: mode = MODE_QPSK;
         RATE_24, RATE_36: mode = MODE_16QAM;
         RATE_48, RATE_54: mode = MODE_64QAM;
         default:          legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/deint_rx_scheduler.sv
// Receive-side deinterleaver sequencer for one 802.11a packet: SIGNAL symbol
// at BPSK, then nsym DATA symbols at the decoded mode, then a timed flush.
module deint_rx_scheduler
   import phy_pkg::*;
#(
   parameter int unsigned NSYM_W       = 10,
   parameter int unsigned SIG_TIMEOUT  = 1024,
   parameter int unsigned FLUSH_CYCLES = 320
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pkt_start,
   input  logic                  abort,
   input  logic [3:0]            sig_rate,
   input  logic [NSYM_W-1:0]     sig_nsym,
   input  logic                  sig_valid,
   input  logic                  sig_error,
   deint_rx_scheduler_if.master  dif,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [NSYM_W-1:0]     sym_count
);

   localparam int unsigned TMR_MAX = (SIG_TIMEOUT > FLUSH_CYCLES) ? SIG_TIMEOUT : FLUSH_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SIG_LAST   = TMR_W'(SIG_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] FLUSH_LAST = TMR_W'(FLUSH_CYCLES - 1);
   localparam logic [8:0]       SIG_BITS_LAST = NCBPS_BPSK - 9'd1;

   state_t            state, state_nxt;
   mode_t             mode_q, mode_nxt, lut_mode;
   logic              lut_legal;
   logic [8:0]        bit_cnt, bit_cnt_nxt, sym_last_bit;
   logic [NSYM_W-1:0] sym_cnt, sym_cnt_nxt, nsym_q, nsym_nxt;
   logic [TMR_W-1:0]  tmr, tmr_nxt;
   logic              ready, accept;
   logic              done_nxt, err_nxt, drst_nxt;
   logic              data_q, valid_q, drst_q, done_q, err_q;

   phy_rate_lut u_rate_lut (
      .rate  (sig_rate),
      .legal (lut_legal),
      .mode  (lut_mode)
   );

   assign ready        = (state == ST_SIG_LOAD) || (state == ST_DATA);
   assign accept       = ready & dif.in_valid;
   assign sym_last_bit = ncbps_of(mode_q) - 9'd1;

   always_comb begin
      state_nxt   = state;
      mode_nxt    = mode_q;
      bit_cnt_nxt = bit_cnt;
      sym_cnt_nxt = sym_cnt;
      nsym_nxt    = nsym_q;
      tmr_nxt     = tmr;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      drst_nxt    = 1'b0;

      if (state != ST_IDLE && abort) begin
         state_nxt = ST_IDLE;
         err_nxt   = 1'b1;
         drst_nxt  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               // abort alongside pkt_start suppresses the start without reporting an error
               if (pkt_start && !abort) begin
                  state_nxt   = ST_SIG_LOAD;
                  mode_nxt    = MODE_BPSK;
                  bit_cnt_nxt = '0;
                  sym_cnt_nxt = '0;
               end
            end
            ST_SIG_LOAD: begin
               if (accept) begin
                  if (bit_cnt == SIG_BITS_LAST) begin
                     state_nxt   = ST_SIG_WAIT;
                     bit_cnt_nxt = '0;
                     tmr_nxt     = '0;
                  end else begin
                     bit_cnt_nxt = bit_cnt + 9'd1;
                  end
               end
            end
            ST_SIG_WAIT: begin
               if (sig_error) begin
                  state_nxt = ST_IDLE;
                  err_nxt   = 1'b1;
               end else if (sig_valid) begin
                  if (lut_legal && sig_nsym != '0) begin
                     state_nxt = ST_RECONF;
                     mode_nxt  = lut_mode;
                     nsym_nxt  = sig_nsym;
                     drst_nxt  = 1'b1;
                  end else begin
                     state_nxt = ST_IDLE;
                     err_nxt   = 1'b1;
                  end
               end else if (tmr == SIG_LAST) begin
                  state_nxt = ST_IDLE;
                  err_nxt   = 1'b1;
               end else begin
                  tmr_nxt = tmr + TMR_W'(1);
               end
            end
            ST_RECONF: begin
               state_nxt   = ST_DATA;
               bit_cnt_nxt = '0;
            end
            ST_DATA: begin
               if (accept) begin
                  if (bit_cnt == sym_last_bit) begin
                     bit_cnt_nxt = '0;
                     if (sym_cnt != '1) begin
                        sym_cnt_nxt = sym_cnt + NSYM_W'(1);
                     end
                     if (sym_cnt == nsym_q - NSYM_W'(1)) begin
                        state_nxt = ST_FLUSH;
                        tmr_nxt   = '0;
                     end
                  end else begin
                     bit_cnt_nxt = bit_cnt + 9'd1;
                  end
               end
            end
            ST_FLUSH: begin
               if (tmr == FLUSH_LAST) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  tmr_nxt = tmr + TMR_W'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         mode_q  <= MODE_BPSK;
         bit_cnt <= '0;
         sym_cnt <= '0;
         nsym_q  <= '0;
         tmr     <= '0;
         data_q  <= 1'b0;
         valid_q <= 1'b0;
         drst_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         mode_q  <= mode_nxt;
         bit_cnt <= bit_cnt_nxt;
         sym_cnt <= sym_cnt_nxt;
         nsym_q  <= nsym_nxt;
         tmr     <= tmr_nxt;
         valid_q <= accept;
         if (accept) begin
            data_q <= dif.in_bit;
         end
         drst_q  <= drst_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
      end
   end

   assign dif.in_ready   = ready;
   assign dif.dint_data  = data_q;
   assign dif.dint_valid = valid_q;
   assign dif.dint_mode  = mode_q;
   assign dif.dint_reset = drst_q;
   assign busy           = (state != ST_IDLE);
   assign done           = done_q;
   assign err            = err_q;
   assign sym_count      = sym_cnt;

endmodule

// File: tb/tb_deint_rx_scheduler.sv
// Self-checking bench for deint_rx_scheduler: rate-table vectors, directed
// packet sequences and randomized packets against a rate/bit-count model.
module tb_deint_rx_scheduler;

   localparam int unsigned NSYM_W       = 10;
   localparam int unsigned SIG_TIMEOUT  = 1024;
   localparam int unsigned FLUSH_CYCLES = 320;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              pkt_start = 1'b0;
   logic              abort = 1'b0;
   logic [3:0]        sig_rate = '0;
   logic [NSYM_W-1:0] sig_nsym = '0;
   logic              sig_valid = 1'b0;
   logic              sig_error = 1'b0;
   logic              busy, done, err;
   logic [NSYM_W-1:0] sym_count;

   deint_rx_scheduler_if dif ();

   deint_rx_scheduler #(
      .NSYM_W       (NSYM_W),
      .SIG_TIMEOUT  (SIG_TIMEOUT),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .pkt_start (pkt_start),
      .abort     (abort),
      .sig_rate  (sig_rate),
      .sig_nsym  (sig_nsym),
      .sig_valid (sig_valid),
      .sig_error (sig_error),
      .dif       (dif),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .sym_count (sym_count)
   );

   always #5 clock = ~clock;

   int unsigned vec = 0;
   int unsigned mis = 0;
   int unsigned n_acc = 0, n_dv = 0, n_drst = 0, n_done = 0, n_err = 0;
   logic        last_acc;

   typedef struct {
      logic [3:0]  rate;
      int unsigned nsym;
      bit          legal;
      logic [1:0]  mode;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // Reference: data rate in Mb/s from the RATE code, 0 when illegal
   function automatic int unsigned rate_mbps(input logic [3:0] r);
      case (r)
         4'b1101: return 6;
         4'b1111: return 9;
         4'b0101: return 12;
         4'b0111: return 18;
         4'b1001: return 24;
         4'b1011: return 36;
         4'b0001: return 48;
         4'b0011: return 54;
         default: return 0;
      endcase
   endfunction

   // NCBPS = NDBPS / coding rate, NDBPS = 4 us * rate
   function automatic int unsigned ncbps_model(input int unsigned mbps);
      int unsigned ndbps;
      ndbps = mbps * 4;
      case (mbps)
         6, 12, 24: return ndbps * 2;
         48:        return ndbps * 3 / 2;
         default:   return ndbps * 4 / 3;
      endcase
   endfunction

   function automatic int unsigned mode_model(input int unsigned ncb);
      case (ncb)
         48:      return 0;
         96:      return 1;
         192:     return 2;
         default: return 3;
      endcase
   endfunction

   // One clock: note whether a bit is accepted at this edge, then check the
   // registered datapath one cycle later.
   task automatic cycle();
      logic acc, b;
      acc = dif.in_valid & dif.in_ready;
      b   = dif.in_bit;
      @(posedge clock);
      #1;
      chk("dint_valid", dif.dint_valid, acc);
      if (acc) chk("dint_data", dif.dint_data, b);
      chk("done_and_err", done & err, 0);
      last_acc = acc;
      n_acc  += acc;
      n_dv   += dif.dint_valid;
      n_drst += dif.dint_reset;
      n_done += done;
      n_err  += err;
      pkt_start = 1'b0;
      abort     = 1'b0;
      sig_valid = 1'b0;
      sig_error = 1'b0;
   endtask

   task automatic start_pkt();
      dif.in_valid = 1'b0;
      pkt_start = 1'b1;
      cycle();
      chk("start_busy", busy, 1);
      chk("start_in_ready", dif.in_ready, 1);
      chk("start_mode", dif.dint_mode, 0);
      chk("start_sym_count", sym_count, 0);
   endtask

   task automatic feed(input int unsigned nbits, input int unsigned gap, input int unsigned ncb,
                       input int unsigned exp_mode, input bit in_data, output int unsigned got);
      int unsigned budget;
      budget = nbits * 20 + 100;
      got = 0;
      while (got < nbits && budget > 0) begin
         dif.in_valid = ($urandom_range(99) >= gap);
         dif.in_bit   = 1'($urandom_range(1));
         if (in_data && $urandom_range(19) == 0) pkt_start = 1'b1;
         if (in_data && $urandom_range(29) == 0) begin
            sig_rate  = 4'b0000;
            sig_valid = 1'b1;
         end
         cycle();
         budget--;
         if (last_acc) got++;
         chk("dint_mode_hold", dif.dint_mode, exp_mode);
         if (in_data) chk("sym_count_run", sym_count, got / ncb);
      end
      dif.in_valid = 1'b0;
      if (got < nbits) chk("feed_budget", got, nbits);
   endtask

   task automatic send_sig(input logic [3:0] rate, input int unsigned nsym, output bit ok);
      int unsigned idle, mbps;
      idle = $urandom_range(5);
      for (int unsigned i = 0; i < idle; i++) begin
         dif.in_valid = 1'($urandom_range(1));
         cycle();
      end
      dif.in_valid = 1'b0;
      sig_rate  = rate;
      sig_nsym  = NSYM_W'(nsym);
      sig_valid = 1'b1;
      cycle();
      mbps = rate_mbps(rate);
      ok = (mbps != 0) && (nsym != 0);
      chk("sig_err", err, !ok);
      chk("sig_busy", busy, ok);
      chk("sig_dint_reset", dif.dint_reset, ok);
      chk("sig_in_ready", dif.in_ready, 0);
      if (ok) chk("sig_mode", dif.dint_mode, mode_model(ncbps_model(mbps)));
   endtask

   task automatic wait_done();
      int unsigned c;
      c = 0;
      do begin
         cycle();
         c++;
      end while (!done && c < FLUSH_CYCLES + 50);
      chk("done_latency", c, FLUSH_CYCLES);
      chk("done_busy", busy, 0);
   endtask

   task automatic run_pkt(input logic [3:0] rate, input int unsigned nsym, input int unsigned gap);
      int unsigned a0, v0, r0, e0, d0, got, ncb, md;
      bit ok;
      a0 = n_acc; v0 = n_dv; r0 = n_drst; e0 = n_err; d0 = n_done;
      start_pkt();
      feed(48, gap, 48, 0, 0, got);
      chk("sig_in_ready_drop", dif.in_ready, 0);
      send_sig(rate, nsym, ok);
      if (ok) begin
         ncb = ncbps_model(rate_mbps(rate));
         md  = mode_model(ncb);
         feed(nsym * ncb, gap, ncb, md, 1, got);
         chk("last_in_ready", dif.in_ready, 0);
         wait_done();
         chk("sym_count_end", sym_count, nsym);
         chk("bits_accepted", n_acc - a0, 48 + nsym * ncb);
         chk("dint_valid_count", n_dv - v0, 48 + nsym * ncb);
         chk("dint_reset_count", n_drst - r0, 1);
         chk("err_count", n_err - e0, 0);
         chk("done_count", n_done - d0, 1);
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            dif.in_valid = 1'b1;
            cycle();
         end
         dif.in_valid = 1'b0;
         chk("rej_bits_accepted", n_acc - a0, 48);
         chk("rej_dint_reset", n_drst - r0, 0);
         chk("rej_done", n_done - d0, 0);
      end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[18];
      int unsigned got, c, r0;
      bit ok;
      logic [3:0] rr;

      tbl[0]  = '{4'b1101, 1, 1'b1, 2'b00};
      tbl[1]  = '{4'b1111, 2, 1'b1, 2'b00};
      tbl[2]  = '{4'b0101, 3, 1'b1, 2'b01};
      tbl[3]  = '{4'b0111, 1, 1'b1, 2'b01};
      tbl[4]  = '{4'b1001, 5, 1'b1, 2'b10};
      tbl[5]  = '{4'b1011, 1, 1'b1, 2'b10};
      tbl[6]  = '{4'b0001, 7, 1'b1, 2'b11};
      tbl[7]  = '{4'b0011, 1023, 1'b1, 2'b11};
      tbl[8]  = '{4'b0000, 1, 1'b0, 2'b00};
      tbl[9]  = '{4'b0010, 1, 1'b0, 2'b00};
      tbl[10] = '{4'b0100, 1, 1'b0, 2'b00};
      tbl[11] = '{4'b0110, 1, 1'b0, 2'b00};
      tbl[12] = '{4'b1000, 1, 1'b0, 2'b00};
      tbl[13] = '{4'b1010, 1, 1'b0, 2'b00};
      tbl[14] = '{4'b1100, 1, 1'b0, 2'b00};
      tbl[15] = '{4'b1110, 1, 1'b0, 2'b00};
      tbl[16] = '{4'b1101, 0, 1'b0, 2'b00};
      tbl[17] = '{4'b0011, 0, 1'b0, 2'b00};

      dif.in_valid = 1'b0;
      dif.in_bit   = 1'b0;

      // reset held for three cycles
      reset = 1'b1;
      for (int unsigned i = 0; i < 3; i++) cycle();
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", dif.in_ready, 0);
      chk("rst_dint_valid", dif.dint_valid, 0);
      chk("rst_dint_mode", dif.dint_mode, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_sym_count", sym_count, 0);
      reset = 1'b0;
      cycle();

      // abort in IDLE does nothing
      abort = 1'b1;
      cycle();
      chk("idle_abort_err", err, 0);
      chk("idle_abort_reset", dif.dint_reset, 0);
      chk("idle_abort_busy", busy, 0);

      // rate table
      for (int i = 0; i < 18; i++) begin
         start_pkt();
         feed(48, 0, 48, 0, 0, got);
         sig_rate  = tbl[i].rate;
         sig_nsym  = NSYM_W'(tbl[i].nsym);
         sig_valid = 1'b1;
         cycle();
         chk("tbl_err", err, !tbl[i].legal);
         chk("tbl_dint_reset", dif.dint_reset, tbl[i].legal);
         chk("tbl_busy", busy, tbl[i].legal);
         if (tbl[i].legal) begin
            chk("tbl_mode", dif.dint_mode, tbl[i].mode);
            abort = 1'b1;
            cycle();
            chk("tbl_abort_err", err, 1);
            chk("tbl_abort_busy", busy, 0);
         end
      end

      // 6 Mb/s, no gaps; 54 Mb/s with 50% gaps
      run_pkt(4'b1101, 2, 0);
      run_pkt(4'b0011, 3, 50);

      // SIGNAL timeout
      r0 = n_drst;
      start_pkt();
      feed(48, 0, 48, 0, 0, got);
      c = 0;
      do begin
         cycle();
         c++;
      end while (!err && c < SIG_TIMEOUT + 20);
      chk("timeout_cycles", c, SIG_TIMEOUT);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_reset", n_drst - r0, 0);

      // sig_valid and sig_error together
      start_pkt();
      feed(48, 0, 48, 0, 0, got);
      sig_rate  = 4'b1101;
      sig_nsym  = NSYM_W'(1);
      sig_valid = 1'b1;
      sig_error = 1'b1;
      cycle();
      chk("both_err", err, 1);
      chk("both_reset", dif.dint_reset, 0);
      chk("both_busy", busy, 0);

      // abort at DATA bit 100 of a 16QAM packet, then restart
      start_pkt();
      feed(48, 0, 48, 0, 0, got);
      send_sig(4'b1001, 2, ok);
      feed(100, 0, 192, 2, 1, got);
      dif.in_valid = 1'b0;
      abort = 1'b1;
      cycle();
      chk("abort_busy", busy, 0);
      chk("abort_reset", dif.dint_reset, 1);
      chk("abort_err", err, 1);
      chk("abort_done", done, 0);
      run_pkt(4'b1101, 1, 0);

      // randomized packets
      for (int unsigned p = 0; p < 8; p++) begin
         if ($urandom_range(3) == 0) rr = 4'($urandom_range(15));
         else rr = {3'($urandom_range(7)), 1'b1};
         run_pkt(rr, $urandom_range(3), $urandom_range(60));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
